rom_loader: RTL and testbench
=============================

# rom_loader

Boot sequencer that copies the program image from the combinational byte ROM into main memory before the core runs. It walks the ROM addresses from 0, packs bytes little-endian into 32-bit words, and writes each word through a request/acknowledge memory write port. It holds the core in reset until the last word is written. It sits between the generated ROM, the memory write port and the core's reset input.

## Interface
- BASE_ADDR, 32'd0: memory byte address that ROM byte 0 is written to; must be 4-byte aligned.
- MAX_BYTES, 65536: safety limit on image length in bytes; must be a multiple of 4.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle load request; sampled only in IDLE or DONE.
- rom_address  out  32  registered byte address presented to the ROM.
- rom_byte  in  8  ROM data for rom_address; combinational, valid in the same cycle.
- rom_done  in  1  high when rom_address is the last image byte; that byte is valid and is loaded.
- mem_addr  out  32  word write address: BASE_ADDR + {rom_address[31:2], 2'b00}.
- mem_data  out  32  assembled word; byte lane n holds ROM byte at word offset n.
- mem_wr_en  out  1  write request; high in WRITE only.
- mem_wr_ack  in  1  memory accepted the write in this cycle.
- cpu_hold  out  1  core reset request; high until the load completes.
- load_done  out  1  image fully written.
- load_error  out  1  MAX_BYTES reached without rom_done.

## Operation
- States: IDLE, FETCH, WRITE, DONE. Reset enters IDLE from any state in the same edge, including mid-load. No pending write survives reset.
- Reset values: rom_address=0, word_buf=0, mem_wr_en=0, cpu_hold=1, load_done=0, load_error=0.
- IDLE: on start=1, clear word_buf and rom_address, go to FETCH. Otherwise stay.
- FETCH: each cycle, capture rom_byte into word_buf lane rom_address[1:0].
  - If rom_address[1:0]==3, or rom_done=1, or rom_address==MAX_BYTES-1: record last = rom_done | (rom_address==MAX_BYTES-1) and go to WRITE.
  - In that case, set load_error if the limit was hit with rom_done=0.
  - Otherwise increment rom_address.
- WRITE: mem_wr_en=1, with mem_data=word_buf and mem_addr as defined above. Both hold stable until mem_wr_ack.
  - On ack with last=1, go to DONE.
  - On ack with last=0, increment rom_address, clear word_buf, and return to FETCH.
  - Without ack, stay in WRITE.
- Partial final word: lanes not fetched are 0. Exactly one write is issued per word.
- DONE: load_done=1, cpu_hold=0. load_error holds its value.
  - On start=1, go to FETCH with rom_address=0, word_buf=0, load_done=0, load_error=0, cpu_hold=1.
- start in FETCH or WRITE is ignored.
- cpu_hold = (state != DONE). load_done = (state == DONE). Both are decoded from the state register and are glitch-free.
- rom_address never exceeds MAX_BYTES-1. Address arithmetic is 32-bit and does not wrap.

## Timing
- Each byte takes one FETCH cycle. Each word takes one WRITE cycle plus any ack wait cycles.
- Start in cycle 0 → FETCH in cycles 1–4 (rom_address 0..3) → WRITE in cycle 5 (ack high).
- With ack tied high, a full word costs 5 cycles. An image of N bytes costs 4·ceil(N/4)... more precisely N FETCH cycles plus ceil(N/4) WRITE cycles.
- 232-byte image with ack tied high: 58 writes, last WRITE in cycle 290, load_done=1 and cpu_hold=0 from cycle 291.
- mem_addr and mem_data change only on the entry edge into WRITE. They never change while mem_wr_en=1 and ack=0.
- Ack arriving in the first WRITE cycle costs 0 extra cycles. Each further wait cycle adds 1 cycle.

## Test plan
- ROM model 232 bytes with bytes 0..3 = 1,0,0,0 and bytes 20..23 = 32,161,7,0, rom_done at 231, ack tied high → 58 writes.
  - Required: write 0 is addr 0, data 32'h00000001; write 5 is addr 20, data 32'h0007A120; load_done in cycle 291.
- Same image, ack delayed 3 cycles per write → mem_addr and mem_data stable during the wait, 58 writes, load_done in cycle 465.
- 6-byte image 0x11..0x16 (rom_done at 5) → 2 writes: 32'h14131211 at BASE, then 32'h00001615 at BASE+4. load_error=0.
- MAX_BYTES=8 with rom_done never high → 2 writes, DONE, load_error=1, rom_address stops at 7.
- Reset asserted during the WRITE of word 10 → next cycle shows IDLE, mem_wr_en=0, cpu_hold=1, rom_address=0. A later start reloads from word 0.
- start pulsed during FETCH → ignored, with the write sequence unchanged. start pulsed in DONE → full reload, load_done drops for the duration of the reload.

Source files
------------

// File: rtl/rom_loader_if.sv
// rom_loader_if: ROM read, memory write and core-control signals of the boot loader
interface rom_loader_if;
  logic        start;
  logic [31:0] rom_address;
  logic [7:0]  rom_byte;
  logic        rom_done;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_wr_en;
  logic        mem_wr_ack;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  modport master (
    input  start, rom_byte, rom_done, mem_wr_ack,
    output rom_address, mem_addr, mem_data, mem_wr_en, cpu_hold, load_done, load_error
  );
  modport slave (
    output start, rom_byte, rom_done, mem_wr_ack,
    input  rom_address, mem_addr, mem_data, mem_wr_en, cpu_hold, load_done, load_error
  );
endinterface

// File: rtl/rom_loader.sv
// rom_loader: copies the byte ROM into memory as little-endian words, holding the core until done
module rom_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int unsigned MAX_BYTES = 65536
) (
  input logic          clk,
  input logic          reset,
  rom_loader_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;
  localparam logic [31:0] LAST = 32'(MAX_BYTES - 1);
  state_t      r_state, w_state;
  logic [31:0] r_addr, w_addr, r_buf, w_buf, w_cap, r_maddr, w_maddr, r_mdata, w_mdata;
  logic        r_last, w_last, r_err, w_err, w_lim, w_end;
  always_comb begin
    w_cap = r_buf;
    w_cap[8*r_addr[1:0] +: 8] = bus.rom_byte;
    w_lim = r_addr == LAST;
    w_end = (&r_addr[1:0]) | bus.rom_done | w_lim;
    w_state = r_state;
    w_addr = r_addr;
    w_buf = r_buf;
    w_last = r_last;
    w_err = r_err;
    w_maddr = r_maddr;
    w_mdata = r_mdata;
    if ((r_state == IDLE || r_state == DONE) && bus.start) begin
      w_state = FETCH;
      w_addr = '0;
      w_buf = '0;
      w_err = 1'b0;
    end else if (r_state == FETCH) begin
      w_buf = w_cap;
      // write port outputs are loaded only on the edge into WRITE so they stay frozen while waiting
      if (w_end) begin
        w_state = WRITE;
        w_last = bus.rom_done | w_lim;
        w_err = r_err | (w_lim & ~bus.rom_done);
        w_maddr = BASE_ADDR + {r_addr[31:2], 2'b00};
        w_mdata = w_cap;
      end else begin
        w_addr = r_addr + 32'd1;
      end
    end else if (r_state == WRITE && bus.mem_wr_ack) begin
      w_state = r_last ? DONE : FETCH;
      w_addr = r_last ? r_addr : r_addr + 32'd1;
      w_buf = r_last ? r_buf : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_buf <= '0;
      r_last <= 1'b0;
      r_err <= 1'b0;
      r_maddr <= BASE_ADDR;
      r_mdata <= '0;
    end else begin
      r_state <= w_state;
      r_addr <= w_addr;
      r_buf <= w_buf;
      r_last <= w_last;
      r_err <= w_err;
      r_maddr <= w_maddr;
      r_mdata <= w_mdata;
    end
  end
  assign bus.rom_address = r_addr;
  assign bus.mem_addr = r_maddr;
  assign bus.mem_data = r_mdata;
  assign bus.mem_wr_en = r_state == WRITE;
  assign bus.cpu_hold = r_state != DONE;
  assign bus.load_done = r_state == DONE;
  assign bus.load_error = r_err;
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed and randomized loads against a word-packing reference model
module tb_rom_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  rom_loader_if b0();
  rom_loader_if b1();
  rom_loader #(.BASE_ADDR(32'd0), .MAX_BYTES(65536)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  rom_loader #(.BASE_ADDR(32'h100), .MAX_BYTES(8)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  logic [7:0]  img0 [256];
  logic [7:0]  img1 [256];
  int          len0 = 232, len1 = 6, ack_dly0 = 0, wcnt0 = 0;
  logic        done_en0 = 1'b1, done_en1 = 1'b1;
  logic [31:0] wa0[$], wd0[$], wa1[$], wd1[$], ea[$], ed[$];
  int          stab_bad0 = 0;
  logic        pend0 = 1'b0;
  logic [31:0] sa0 = '0, sd0 = '0;
  int          passed = 0, total = 0;
  assign b0.rom_byte = (b0.rom_address < 32'd256) ? img0[b0.rom_address[7:0]] : 8'h00;
  assign b0.rom_done = done_en0 && (b0.rom_address == 32'(len0 - 1));
  assign b0.mem_wr_ack = b0.mem_wr_en && (wcnt0 == ack_dly0);
  assign b1.rom_byte = (b1.rom_address < 32'd256) ? img1[b1.rom_address[7:0]] : 8'h00;
  assign b1.rom_done = done_en1 && (b1.rom_address == 32'(len1 - 1));
  assign b1.mem_wr_ack = 1'b1;
  always @(posedge clk) wcnt0 <= (b0.mem_wr_en && !b0.mem_wr_ack) ? wcnt0 + 1 : 0;
  // write collector and hold-while-stalled watcher
  always @(negedge clk) begin
    if (b0.mem_wr_en && pend0 && (b0.mem_addr !== sa0 || b0.mem_data !== sd0)) stab_bad0++;
    pend0 = b0.mem_wr_en && !b0.mem_wr_ack;
    sa0 = b0.mem_addr;
    sd0 = b0.mem_data;
    if (b0.mem_wr_en && b0.mem_wr_ack) begin
      wa0.push_back(b0.mem_addr);
      wd0.push_back(b0.mem_data);
    end
    if (b1.mem_wr_en) begin
      wa1.push_back(b1.mem_addr);
      wd1.push_back(b1.mem_data);
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic model(input int n, input logic [31:0] base, input bit which);
    logic [31:0] word;
    ea.delete();
    ed.delete();
    for (int w = 0; w < (n + 3) / 4; w++) begin
      word = '0;
      for (int k = 0; k < 4; k++)
        if (4 * w + k < n) word[8*k +: 8] = which ? img1[4*w+k] : img0[4*w+k];
      ea.push_back(base + 32'(4 * w));
      ed.push_back(word);
    end
  endtask
  task automatic cmp_writes(input string tag, input bit which);
    int nw;
    nw = which ? wa1.size() : wa0.size();
    chk({tag, "_count"}, 64'(nw), 64'(ea.size()));
    for (int i = 0; i < nw && i < ea.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), which ? wa1[i] : wa0[i], ea[i]);
      chk($sformatf("%s_data%0d", tag, i), which ? wd1[i] : wd0[i], ed[i]);
    end
  endtask
  task automatic go0(input string tag, input int n, input int dly, input int pulse_at);
    int cyc;
    ack_dly0 = dly;
    @(negedge clk);
    wa0.delete();
    wd0.delete();
    stab_bad0 = 0;
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    cyc = 1;
    chk({tag, "_done_low"}, b0.load_done, 0);
    chk({tag, "_hold_high"}, b0.cpu_hold, 1);
    while (!b0.load_done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      b0.start = (cyc == pulse_at);
    end
    b0.start = 1'b0;
    model(n, 32'd0, 1'b0);
    chk({tag, "_done_cycle"}, 64'(cyc), 64'(n + ((n + 3) / 4) * (dly + 1) + 1));
    cmp_writes(tag, 1'b0);
    chk({tag, "_stable"}, 64'(stab_bad0), 0);
    chk({tag, "_err"}, b0.load_error, 0);
    chk({tag, "_hold_low"}, b0.cpu_hold, 0);
  endtask
  task automatic go1(input string tag, input int n, input logic err, input logic [31:0] ra);
    int cyc;
    @(negedge clk);
    wa1.delete();
    wd1.delete();
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    cyc = 1;
    while (!b1.load_done && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    model(n, 32'h100, 1'b1);
    chk({tag, "_done_cycle"}, 64'(cyc), 64'(n + (n + 3) / 4 + 1));
    cmp_writes(tag, 1'b1);
    chk({tag, "_err"}, b1.load_error, err);
    chk({tag, "_rom_addr"}, b1.rom_address, ra);
  endtask
  initial begin
    int k;
    b0.start = 1'b0;
    b1.start = 1'b0;
    for (int i = 0; i < 256; i++) img0[i] = 8'($urandom);
    img0[0] = 8'd1;  img0[1] = 8'd0;   img0[2] = 8'd0; img0[3] = 8'd0;
    img0[20] = 8'd32; img0[21] = 8'd161; img0[22] = 8'd7; img0[23] = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_addr0", b0.rom_address, 0);
    chk("rst_wren0", b0.mem_wr_en, 0);
    chk("rst_hold0", b0.cpu_hold, 1);
    chk("rst_done0", b0.load_done, 0);
    chk("rst_err0", b0.load_error, 0);
    chk("rst_hold1", b1.cpu_hold, 1);
    chk("rst_done1", b1.load_done, 0);
    reset = 1'b0;
    go0("img232", 232, 0, 0);
    chk("w0_addr", wa0[0], 32'h0);
    chk("w0_data", wd0[0], 32'h00000001);
    chk("w5_addr", wa0[5], 32'd20);
    chk("w5_data", wd0[5], 32'h0007A120);
    go0("img232_ack3", 232, 3, 0);
    ack_dly0 = 2;
    @(negedge clk);
    wa0.delete();
    wd0.delete();
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!(wa0.size() == 10 && b0.mem_wr_en) && k < 3000);
    chk("midrst_reached", 64'(wa0.size()), 10);
    chk("midrst_in_write", b0.mem_wr_en, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_wren", b0.mem_wr_en, 0);
    chk("midrst_hold", b0.cpu_hold, 1);
    chk("midrst_addr", b0.rom_address, 0);
    chk("midrst_done", b0.load_done, 0);
    repeat (4) @(negedge clk);
    chk("midrst_nowrite", 64'(wa0.size()), 10);
    chk("midrst_idle_wren", b0.mem_wr_en, 0);
    go0("reload", 232, 0, 0);
    for (int t = 0; t < 4; t++) begin
      len0 = $urandom_range(1, 200);
      for (int i = 0; i < 256; i++) img0[i] = 8'($urandom);
      go0($sformatf("rnd%0d", t), len0, $urandom_range(0, 2), $urandom_range(2, len0 + 1));
    end
    for (int i = 0; i < 256; i++) img1[i] = 8'($urandom);
    done_en1 = 1'b0;
    go1("limit8", 8, 1'b1, 32'd7);
    for (int i = 0; i < 6; i++) img1[i] = 8'(8'h11 + i);
    len1 = 6;
    done_en1 = 1'b1;
    go1("six", 6, 1'b0, 32'd5);
    chk("six_w0_addr", wa1[0], 32'h100);
    chk("six_w0_data", wd1[0], 32'h14131211);
    chk("six_w1_addr", wa1[1], 32'h104);
    chk("six_w1_data", wd1[1], 32'h00001615);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
